pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 16 +
 rtl/pc_fetch_if.sv | 22 ++
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_fetch.sv | 57 +++++
 tb/tb_pc_fetch.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage encodings: next-PC selects, fetch FSM states and
// the default reset/trap addresses used by pc_fetch and decode/control.
package pc_fetch_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: control-side next-PC inputs and fetch-side status outputs.
interface pc_fetch_if;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_cnt;

  modport master (
    output stall, pc_src, imm, rs1,
    input  pc, pc_plus4, halted, misalign, fetch_cnt
  );

  modport slave (
    input  stall, pc_src, imm, rs1,
    output pc, pc_plus4, halted, misalign, fetch_cnt
  );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC target selection and word-alignment check.
module pc_next_mux
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        aligned
);

  logic [31:0] jalr_sum;

  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1 + imm;

  always_comb begin
    target = pc_plus4;
    unique case (pc_src)
      PC_SEQ:  target = pc_plus4;
      PC_BR:   target = pc + imm;
      PC_JALR: target = {jalr_sum[31:1], 1'b0};
      PC_TRAP: target = TRAP_VEC;
      default: target = pc_plus4;
    endcase
  end

  assign aligned = (target[1:0] == 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// Program counter for a single-cycle core: RUN/HALT FSM, fetch counter and
// sticky misalignment flag; a misaligned target halts fetch until reset.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.slave  bus
);

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  logic        misalign_q;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        aligned;

  pc_next_mux #(
    .TRAP_VEC (TRAP_VEC)
  ) u_next (
    .pc       (pc_q),
    .pc_src   (bus.pc_src),
    .imm      (bus.imm),
    .rs1      (bus.rs1),
    .pc_plus4 (pc_plus4),
    .target   (target),
    .aligned  (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else if (state == ST_RUN && !bus.stall) begin
      if (aligned) begin
        pc_q  <= target;
        cnt_q <= cnt_q + 32'd1;
      end else begin
        misalign_q <= 1'b1;
        state      <= ST_HALT;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.halted    = (state == ST_HALT);
  assign bus.misalign  = misalign_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a reference model queues expected outputs
// per driven cycle; they are popped and compared one cycle later.
module tb_pc_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] cnt;
    logic        halted;
    logic        misalign;
  } exp_t;

  logic clk;
  logic reset;
  pc_fetch_if bus();

  exp_t sb[$];
  int   checks;
  int   errors;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halt;
  logic        m_mis;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare the DUT after the edge.
  task automatic cycle(input logic rst, input logic st, input logic [1:0] src,
                       input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] tgt;
    logic [31:0] js;
    exp_t        e;
    exp_t        o;
    reset      = rst;
    bus.stall  = st;
    bus.pc_src = src;
    bus.imm    = im;
    bus.rs1    = r1;
    js = r1 + im;
    case (src)
      2'b00:   tgt = m_pc + 32'd4;
      2'b01:   tgt = m_pc + im;
      2'b10:   tgt = js & 32'hFFFF_FFFE;
      default: tgt = 32'h0000_0100;
    endcase
    if (rst) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
    end else if (!m_halt && !st) begin
      if (tgt[1:0] == 2'b00) begin
        m_pc  = tgt;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_mis  = 1'b1;
        m_halt = 1'b1;
      end
    end
    e.pc = m_pc; e.pc_plus4 = m_pc + 32'd4; e.cnt = m_cnt;
    e.halted = m_halt; e.misalign = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check_val("pc",        bus.pc,        o.pc);
    check_val("pc_plus4",  bus.pc_plus4,  o.pc_plus4);
    check_val("fetch_cnt", bus.fetch_cnt, o.cnt);
    check_val("halted",    {31'b0, bus.halted},   {31'b0, o.halted});
    check_val("misalign",  {31'b0, bus.misalign}, {31'b0, o.misalign});
  endtask

  initial begin
    checks = 0; errors = 0;
    m_pc = '0; m_cnt = '0; m_halt = 1'b0; m_mis = 1'b0;
    reset = 1'b1; bus.stall = 1'b0; bus.pc_src = 2'b00; bus.imm = '0; bus.rs1 = '0;

    // Reset state, then five sequential advances
    cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("rst_pc", bus.pc, 32'h0);
    check_val("rst_pc4", bus.pc_plus4, 32'h4);
    for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("seq_pc", bus.pc, 32'd20);
    check_val("seq_cnt", bus.fetch_cnt, 32'd5);
    check_val("seq_pc4", bus.pc_plus4, 32'd24);

    // Branch backward from pc=8, then forward
    cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("pre_br_pc", bus.pc, 32'h8);
    cycle(1'b0, 1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0);
    check_val("br_back", bus.pc, 32'h0);
    cycle(1'b0, 1'b0, 2'b01, 32'h0000_0040, 32'h0);
    check_val("br_fwd", bus.pc, 32'h40);

    // Stall ignores a misaligned branch; releasing the stall goes sequential
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b01, 32'h2, 32'h0);
    check_val("stall_mis", {31'b0, bus.misalign}, 32'h0);
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("unstall_pc", bus.pc, 32'h44);

    // JALR clears bit 0; misaligned JALR halts and holds
    cycle(1'b0, 1'b0, 2'b10, 32'h4, 32'h101);
    check_val("jalr_pc", bus.pc, 32'h104);
    cycle(1'b0, 1'b0, 2'b10, 32'h0, 32'h102);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("halt_pc", bus.pc, 32'h104);
    check_val("halt_flag", {31'b0, bus.halted}, 32'h1);

    // Reset while halted with stall asserted
    cycle(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    check_val("halt_rst_pc", bus.pc, 32'h0);
    check_val("halt_rst_h", {31'b0, bus.halted}, 32'h0);

    // Wrap at top of address space, then trap vector
    cycle(1'b0, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    check_val("top_pc", bus.pc, 32'hFFFF_FFFC);
    check_val("top_pc4", bus.pc_plus4, 32'h0);
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_val("wrap_pc", bus.pc, 32'h0);
    cycle(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    check_val("trap_pc", bus.pc, 32'h100);

    // Randomised mix of selects, stalls and occasional resets
    for (int unsigned i = 0; i < 60; i++) begin
      logic [31:0] ri;
      logic [31:0] rr;
      ri = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 3) != 0) ri[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rr[1:0] = 2'b00;
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), ri, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
